arb_out_fifo: RTL

- Buffering stage directly downstream of the two-slave arbiter.
- Captures each granted word together with its sideband (mode, proc_val, source id).
- Presents entries first-word-fall-through to the processing engine over a valid/ready pop interface.
- Generates the fifo_full back-pressure the arbiter samples, with skid headroom for the arbiter's registered reaction latency.

---
 rtl/arb_pkg.sv | 31 +++
 rtl/arb_fifo_mem.sv | 29 ++
 rtl/arb_out_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter-side definitions: mode/source encodings and the FIFO entry layout.
// The entry payload width follows ARB_DW; override that macro at build time to
// change the data width seen by arb_out_fifo.
`ifndef ARB_DW
`define ARB_DW 32
`endif

package arb_pkg;

  localparam int unsigned ARB_DW = `ARB_DW;

  // Mode encodings carried alongside each granted word.
  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_SLV0 = 2'b01;
  localparam logic [1:0] MODE_SLV1 = 2'b10;

  // Arbiter data_source encodings.
  localparam logic SRC_SLV0 = 1'b0;
  localparam logic SRC_SLV1 = 1'b1;

  // One buffered word plus its sideband, packed MSB-first as {mode, proc_val, source, data}.
  typedef struct packed {
    logic [1:0]        mode;
    logic [7:0]        proc_val;
    logic              source;
    logic [ARB_DW-1:0] data;
  } arb_entry_t;

  localparam int unsigned ENTRY_W = $bits(arb_entry_t);

endpackage

// File: rtl/arb_fifo_mem.sv
// Entry storage for arb_out_fifo: one synchronous write port, one asynchronous
// read port. Pure storage, no control logic.
module arb_fifo_mem #(
  parameter  int unsigned W     = 43,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Capture the write entry at the write pointer.
  // NOTE: the array has no reset; entries are only observable after a push,
  // and the empty mask in the parent hides stale contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/arb_out_fifo.sv
// Output FIFO behind the two-slave arbiter: buffers granted words with their
// sideband, presents them first-word-fall-through, and raises fifo_full early
// enough that SKID in-flight words still fit.
// Optional build macro: ARB_OUT_FIFO_SRC_STATS_EN adds per-source accepted-word
// counters (src0_words, src1_words).
module arb_out_fifo
  import arb_pkg::*;
#(
  parameter  int unsigned DW    = ARB_DW,
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned SKID  = 1,
  localparam int unsigned CW    = $clog2(DEPTH) + 1,
  localparam int unsigned AW    = CW - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  input  logic [1:0]    wr_mode,
  input  logic [7:0]    wr_proc_val,
  input  logic          wr_source,
  output logic          fifo_full,
  output logic          fifo_almost_empty,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    rd_mode,
  output logic [7:0]    rd_proc_val,
  output logic          rd_source,
  output logic [CW-1:0] fifo_count,
`ifdef ARB_OUT_FIFO_SRC_STATS_EN
  output logic [15:0]   src0_words,
  output logic [15:0]   src1_words,
`endif
  output logic          ovf_err,
  input  logic          clr_err
);

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, drop;

  arb_entry_t           wr_entry;
  arb_entry_t           rd_entry;
  logic [ENTRY_W-1:0]   mem_rdata;

  // Handshake decode, pointer/count/flag next-state.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pop      = (count_q != '0) && rd_ready;
    push     = wr_valid && ((count_q < CW'(DEPTH)) || pop);
    drop     = wr_valid && !push;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Threshold on the next count so fifo_full rises on the edge it is reached.
    full_d = (count_d >= CW'(DEPTH - SKID));
    // A new overflow beats a same-cycle clear.
    if (drop)         ovf_d = 1'b1;
    else if (clr_err) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // Control state register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // Pack the incoming word and sideband into one entry.
  always_comb begin
    wr_entry          = '0;
    wr_entry.mode     = wr_mode;
    wr_entry.proc_val = wr_proc_val;
    wr_entry.source   = wr_source;
    wr_entry.data     = wr_data;
  end

  arb_fifo_mem #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Head presentation, forced to zero while empty.
  always_comb begin
    rd_entry = '0;
    if (rd_valid) rd_entry = arb_entry_t'(mem_rdata);
  end

  assign rd_valid          = (count_q != '0);
  assign rd_data           = rd_entry.data;
  assign rd_mode           = rd_entry.mode;
  assign rd_proc_val       = rd_entry.proc_val;
  assign rd_source         = rd_entry.source;
  assign fifo_count        = count_q;
  assign fifo_almost_empty = (count_q <= CW'(1));
  assign fifo_full         = full_q;
  assign ovf_err           = ovf_q;

`ifdef ARB_OUT_FIFO_SRC_STATS_EN
  logic [15:0] src0_q, src0_d;
  logic [15:0] src1_q, src1_d;

  // Saturating per-source counts of accepted pushes; clr_err zeroes both.
  always_comb begin
    src0_d = src0_q;
    src1_d = src1_q;
    if (clr_err) begin
      src0_d = '0;
      src1_d = '0;
    end else if (push) begin
      if (wr_source == SRC_SLV0) begin
        if (src0_q != 16'hFFFF) src0_d = src0_q + 16'd1;
      end else begin
        if (src1_q != 16'hFFFF) src1_d = src1_q + 16'd1;
      end
    end
  end

  // Stats counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src0_q <= '0;
      src1_q <= '0;
    end else begin
      src0_q <= src0_d;
      src1_q <= src1_d;
    end
  end

  assign src0_words = src0_q;
  assign src1_words = src1_q;
`endif

endmodule
